dwbmem_loader: RTL

Wishbone pipelined master that fills the BRAM memory from a byte stream at boot. It sits directly upstream of the BRAM memory's Wishbone slave port: it accepts bytes on a valid/ready interface and packs them little-endian into 32-bit words. It then issues single-word pipelined writes to consecutive addresses, handling stall and ack. With verification compiled in, it can read the image back and check it.

---
 rtl/dwbmem_loader_pkg.sv | 19 +
 rtl/dwbmem_loader_packer.sv | 42 ++++
 rtl/dwbmem_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dwbmem_loader_pkg.sv
// Shared types and constants for the boot-time BRAM loader.
package dwbmem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StReq,
        StWaitAck,
        StRdReq,
        StRdWait,
        StDone
    } state_e;

    localparam logic [7:0]  ACK_TIMEOUT         = 8'd255;
    localparam int unsigned DEPTH_WORDS_DEFAULT = 256;
    // Wide enough to hold a length of exactly DEPTH_WORDS.
    localparam int unsigned IDX_W               = $clog2(DEPTH_WORDS_DEFAULT) + 1;

endpackage

// File: rtl/dwbmem_loader_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words.
module dwbmem_loader_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic        byte_ready_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d;
    logic        accept;

    assign accept = byte_valid_i & byte_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (accept) begin
            cnt_d = cnt_q + 2'd1;
            // Newest byte enters at the top so byte 0 ends up in bits [7:0].
            sh_d  = {byte_data_i, sh_q[23:8]};
        end
    end

    assign word_valid_o = accept && (cnt_q == 2'd3);
    assign word_o       = {byte_data_i, sh_q};

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= 2'd0;
            sh_q  <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/dwbmem_loader.sv
// Wishbone pipelined master filling BRAM from a byte stream at boot.
// Define DWBMEM_LOADER_VERIFY_EN to add checksum-based readback verification.
module dwbmem_loader
    import dwbmem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [8:0]  len_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_inc;
    logic [31:0]      dat_q, dat_d;
    logic             err_q, err_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             pk_clr;
    logic             pk_valid;
    logic [31:0]      pk_word;
    logic             last_word;
    logic             tmo_hit;

`ifdef DWBMEM_LOADER_VERIFY_EN
    logic [31:0] wsum_q, wsum_d;
    logic [31:0] rsum_q, rsum_d;
`else
    logic unused_dat_i;
    assign unused_dat_i = ^wb_dat_i;
`endif

    assign idx_inc   = idx_q + IDX_W'(1);
    assign last_word = (idx_inc == len_q);
    assign tmo_hit   = (tmo_q == ACK_TIMEOUT - 8'd1);

    dwbmem_loader_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (pk_clr),
        .byte_valid_i (byte_valid_i),
        .byte_ready_i (byte_ready_o),
        .byte_data_i  (byte_data_i),
        .word_valid_o (pk_valid),
        .word_o       (pk_word)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        pk_clr  = 1'b0;
`ifdef DWBMEM_LOADER_VERIFY_EN
        wsum_d  = wsum_q;
        rsum_d  = rsum_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (32'(len_i) > DEPTH_WORDS) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (len_i != '0) begin
                        len_d   = len_i;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        pk_clr  = 1'b1;
`ifdef DWBMEM_LOADER_VERIFY_EN
                        wsum_d  = 32'd0;
                        rsum_d  = 32'd0;
`endif
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (pk_valid) begin
                    dat_d   = pk_word;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!wb_stall_i) begin
                    tmo_d   = 8'd0;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (wb_ack_i) begin
                    idx_d = idx_inc;
`ifdef DWBMEM_LOADER_VERIFY_EN
                    wsum_d = wsum_q + dat_q;
                    if (last_word) begin
                        idx_d   = '0;
                        state_d = StRdReq;
                    end else begin
                        state_d = StFill;
                    end
`else
                    state_d = last_word ? StDone : StFill;
`endif
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
`ifdef DWBMEM_LOADER_VERIFY_EN
            StRdReq: begin
                if (!wb_stall_i) begin
                    tmo_d   = 8'd0;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (wb_ack_i) begin
                    idx_d  = idx_inc;
                    rsum_d = rsum_q + wb_dat_i;
                    if (last_word) begin
                        if (rsum_d != wsum_q) err_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StRdReq;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_ready_o = (state_q == StFill);
        wb_stb_o     = (state_q == StReq);
        wb_cyc_o     = (state_q == StReq) || (state_q == StWaitAck);
`ifdef DWBMEM_LOADER_VERIFY_EN
        wb_stb_o     = wb_stb_o || (state_q == StRdReq);
        wb_cyc_o     = wb_cyc_o || (state_q == StRdReq) || (state_q == StRdWait);
`endif
        wb_we_o      = (state_q == StReq);
        wb_sel_o     = wb_stb_o ? 4'hF : 4'h0;
        wb_adr_o     = wb_stb_o ? BASE_ADDR + {21'd0, idx_q, 2'b00} : 32'd0;
        wb_dat_o     = (state_q == StReq) ? dat_q : 32'd0;
        busy_o       = wb_cyc_o || (state_q == StFill);
        done_o       = (state_q == StDone);
        err_o        = err_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
            dat_q   <= 32'd0;
            err_q   <= 1'b0;
            tmo_q   <= 8'd0;
`ifdef DWBMEM_LOADER_VERIFY_EN
            wsum_q  <= 32'd0;
            rsum_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
`ifdef DWBMEM_LOADER_VERIFY_EN
            wsum_q  <= wsum_d;
            rsum_q  <= rsum_d;
`endif
        end
    end

endmodule
